play_timer: RTL
===============

Name: play_timer

Overview:
- Parametrised playback-time counter for the MP3 player. It tracks elapsed or remaining time of the current track as minute:second.
- Per-track length, play/pause, next/previous restart, end-of-song pulse and optional BCD display outputs.
- Sits between the player control FSM and the seven-segment/LCD display driver.
- The one-second tick comes from an internal clock-enable prescaler, not a derived clock. The whole block runs on clk.

Parameters:
- CLK_FREQ, 100000000, clk cycles per one-second tick (>=2).
- MIN_W, 8, width of the minute counters and outputs.
- AUTO_RESTART, 0: 1 means that at end of song, finish pulses and the timer restarts from 0:00 in PLAYING; 0 means it stops in DONE.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- start, in, 1: one-cycle pulse; load length, clear time, enter PLAYING.
- play_pause, in, 1: one-cycle pulse; toggles PLAYING and PAUSED.
- next, in, 1: one-cycle pulse; restart current time at 0:00 with newly sampled length.
- pre, in, 1: one-cycle pulse; same action as next.
- len_min, in, MIN_W: track length, minutes; sampled on start/next/pre.
- len_sec, in, 6: track length, seconds; sampled; values >59 clamp to 59.
- countdown, in, 1: 0 shows elapsed, 1 shows remaining; may change at any time and affects outputs combinationally.
- minute, out, MIN_W: displayed minutes.
- second, out, 6: displayed seconds, 0..59.
- running, out, 1: high in PLAYING.
- finish, out, 1: one-cycle pulse at end of song.

Behaviour:
- Reset values: state IDLE; prescaler 0; elapsed 0:00; remaining 0:00; stored length 0:00; minute=0, second=0, running=0, finish=0.
- States:
  - IDLE: counters hold. start/next/pre go to PLAYING. play_pause is ignored.
  - PLAYING: prescaler increments each cycle. At CLK_FREQ-1 it wraps to 0 and issues tick. On tick, elapsed increments (second 59 -> 0 with minute+1), and remaining decrements (second 0 -> 59 with minute-1).
  - PAUSED: prescaler and counters hold; the prescaler is NOT cleared, so the partial second is preserved. play_pause returns to PLAYING.
  - DONE: elapsed = length, remaining = 0:00. start/next/pre go to PLAYING. play_pause is ignored.
- End of song: tick when elapsed equals length minus one second. That tick makes elapsed = length, and finish is registered high in the following cycle for exactly one cycle.
  - AUTO_RESTART=0: the same tick enters DONE.
  - AUTO_RESTART=1: in the cycle after the end tick, elapsed clears to 0:00, remaining reloads to length, and the state stays PLAYING.
- Restart (start/next/pre):
  - elapsed <= 0:00, remaining <= sampled length, prescaler <= 0.
  - Takes effect in the same edge; outputs show new values the next cycle.
  - Legal in any state, including mid-second.
- Zero length 0:00 on restart: go directly to DONE; finish pulses the next cycle; no counting.
- Priority, highest first: rst > next/pre/start > play_pause > tick. A tick coinciding with a restart is discarded. A tick coinciding with play_pause into PAUSED is still applied.
- Minute wrap: elapsed minute increments modulo 2^MIN_W. Length always bounds it in practice.
- Outputs:
  - minute/second = countdown ? remaining : elapsed, both registered sources.
  - running = (state==PLAYING).
  - Latency from an input pulse to its output change: 1 cycle.

Optional Feature:
- Macro PLAY_TIMER_BCD_EN.
- Defined: extra outputs min_bcd[7:0] and sec_bcd[7:0], two packed BCD digits each, derived from minute/second and registered (1 extra cycle). Minutes >99 saturate to 8'h99.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package play_timer_pkg holds:
  - the state enum (IDLE, PLAYING, PAUSED, DONE);
  - SEC_MAX=59;
  - SEC_W=6.
- One natural sub-module: tick_gen (parameter CLK_FREQ; inputs clk, rst, en, clr; output tick). It is reusable by other display and animation blocks.

Test Plan:
- CLK_FREQ=4, len 0:03, start -> ticks at cycles 4, 8, 12 give elapsed 0:01, 0:02, 0:03; finish high exactly one cycle after the third tick; state DONE; running=0.
- len 1:00, countdown=1, start, run 1 tick -> minute=0, second=59; after 60 ticks minute=0, second=0, and finish pulses.
- Elapsed 0:59 then tick -> 1:00 (second wrap, minute carry); play_pause at prescaler=2, wait 20 cycles, play_pause -> next tick arrives 2 cycles after resume, and counters are unchanged during the pause.
- next asserted in the same cycle as a tick at 0:05 -> 0:00, prescaler 0, no increment; len_sec=63 sampled -> stored length 0:59.
- AUTO_RESTART=1, len 0:02 -> after the 2nd tick finish pulses and elapsed returns to 0:00, running stays 1; rst mid-second -> all outputs 0 next cycle. With PLAY_TIMER_BCD_EN, elapsed 1:37 -> min_bcd=8'h01, sec_bcd=8'h37.

Source files
------------

// File: rtl/play_timer_pkg.sv
// play_timer_pkg: shared types and constants for the playback-time counter.
//   state_e : control states (IDLE, PLAYING, PAUSED, DONE)
//   SEC_W   : width of a seconds field
//   SEC_MAX : largest legal seconds value
//   to_bcd  : 0..99 binary value to two packed BCD digits
package play_timer_pkg;

    localparam int unsigned SEC_W   = 6;
    localparam int unsigned SEC_MAX = 59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Binary 0..99 to {tens, ones} BCD digits.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = v / 7'd10;
        ones = v - (tens * 7'd10);
        return {4'(tens), 4'(ones)};
    endfunction

endpackage

// File: rtl/play_timer_tick_gen.sv
// tick_gen: clock-enable prescaler producing a one-cycle tick every CLK_FREQ
// enabled cycles. Holds its count while en is low so partial periods survive.
//   clk  : clock
//   rst  : synchronous active-high reset
//   en   : count enable
//   clr  : clear count to 0 (wins over en, suppresses tick)
//   tick : high in the cycle the count wraps (combinational from count/en/clr)
module tick_gen #(
    parameter int unsigned CLK_FREQ = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and tick strobe.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/play_timer.sv
// play_timer: minute:second playback counter for the current track.
// Tracks elapsed and remaining time, runs from a one-second clock-enable,
// supports play/pause, restart (start/next/pre) and flags end of song.
// Optional feature macro: PLAY_TIMER_BCD_EN adds registered BCD outputs.
//   clk, rst            : clock, synchronous active-high reset
//   start/next/pre      : one-cycle restart pulses (sample length, clear time)
//   play_pause          : one-cycle toggle between PLAYING and PAUSED
//   len_min, len_sec    : track length (seconds clamp to 59)
//   countdown           : 1 shows remaining, 0 shows elapsed (combinational)
//   minute, second      : displayed time
//   running             : high while PLAYING
//   finish              : one-cycle end-of-song pulse
//   min_bcd, sec_bcd    : (PLAY_TIMER_BCD_EN) packed BCD of minute/second
module play_timer
    import play_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned MIN_W        = 8,
    parameter bit          AUTO_RESTART = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             play_pause,
    input  logic             next,
    input  logic             pre,
    input  logic [MIN_W-1:0] len_min,
    input  logic [SEC_W-1:0] len_sec,
    input  logic             countdown,
    output logic [MIN_W-1:0] minute,
    output logic [SEC_W-1:0] second,
    output logic             running,
    output logic             finish
`ifdef PLAY_TIMER_BCD_EN
    ,
    output logic [7:0]       min_bcd,
    output logic [7:0]       sec_bcd
`endif
);

    state_e           state_q,   state_d;
    logic [MIN_W-1:0] ela_min_q, ela_min_d;
    logic [SEC_W-1:0] ela_sec_q, ela_sec_d;
    logic [MIN_W-1:0] rem_min_q, rem_min_d;
    logic [SEC_W-1:0] rem_sec_q, rem_sec_d;
    logic [MIN_W-1:0] len_min_q, len_min_d;
    logic [SEC_W-1:0] len_sec_q, len_sec_d;
    logic             finish_q,  finish_d;
    logic             running_q, running_d;
    logic             wrap_q,    wrap_d;

    logic             restart;
    logic             tick;
    logic [SEC_W-1:0] smp_sec;

    assign restart = start | next | pre;
    assign smp_sec = (len_sec > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : len_sec;

    // Prescaler runs only while PLAYING; a restart re-phases it to 0.
    tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == PLAYING),
        .clr  (restart),
        .tick (tick)
    );

    // Next-state and counter update; restart > play_pause > tick.
    always_comb begin
        state_d   = state_q;
        ela_min_d = ela_min_q;
        ela_sec_d = ela_sec_q;
        rem_min_d = rem_min_q;
        rem_sec_d = rem_sec_q;
        len_min_d = len_min_q;
        len_sec_d = len_sec_q;
        finish_d  = 1'b0;
        wrap_d    = 1'b0;

        // Auto-restart: the end value is shown for one cycle, then rewinds.
        if (wrap_q) begin
            ela_min_d = '0;
            ela_sec_d = '0;
            rem_min_d = len_min_q;
            rem_sec_d = len_sec_q;
        end

        if (restart) begin
            len_min_d = len_min;
            len_sec_d = smp_sec;
            ela_min_d = '0;
            ela_sec_d = '0;
            rem_min_d = len_min;
            rem_sec_d = smp_sec;
            if ((len_min == '0) && (smp_sec == '0)) begin
                state_d  = DONE;
                finish_d = 1'b1;
            end else begin
                state_d  = PLAYING;
            end
        end else begin
            case (state_q)
                PLAYING: if (play_pause) state_d = PAUSED;
                PAUSED:  if (play_pause) state_d = PLAYING;
                default: ;
            endcase

            // tick is only ever raised while PLAYING.
            if (tick) begin
                if (ela_sec_q == SEC_W'(SEC_MAX)) begin
                    ela_sec_d = '0;
                    ela_min_d = ela_min_q + MIN_W'(1);
                end else begin
                    ela_sec_d = ela_sec_q + SEC_W'(1);
                end
                if (rem_sec_q == '0) begin
                    rem_sec_d = SEC_W'(SEC_MAX);
                    rem_min_d = rem_min_q - MIN_W'(1);
                end else begin
                    rem_sec_d = rem_sec_q - SEC_W'(1);
                end
                if ((ela_min_d == len_min_q) && (ela_sec_d == len_sec_q)) begin
                    finish_d = 1'b1;
                    if (AUTO_RESTART) begin
                        wrap_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
        end

        running_d = (state_d == PLAYING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ela_min_q <= '0;
            ela_sec_q <= '0;
            rem_min_q <= '0;
            rem_sec_q <= '0;
            len_min_q <= '0;
            len_sec_q <= '0;
            finish_q  <= 1'b0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ela_min_q <= ela_min_d;
            ela_sec_q <= ela_sec_d;
            rem_min_q <= rem_min_d;
            rem_sec_q <= rem_sec_d;
            len_min_q <= len_min_d;
            len_sec_q <= len_sec_d;
            finish_q  <= finish_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

    // Display select between the two registered time sources.
    assign minute  = countdown ? rem_min_q : ela_min_q;
    assign second  = countdown ? rem_sec_q : ela_sec_q;
    assign running = running_q;
    assign finish  = finish_q;

`ifdef PLAY_TIMER_BCD_EN
    logic [7:0] min_bcd_q, min_bcd_d;
    logic [7:0] sec_bcd_q, sec_bcd_d;

    // BCD of the displayed time, minutes saturating at 99.
    always_comb begin
        min_bcd_d = (32'(minute) > 32'd99) ? 8'h99 : to_bcd(7'(minute));
        sec_bcd_d = to_bcd(7'(second));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_bcd_q <= '0;
            sec_bcd_q <= '0;
        end else begin
            min_bcd_q <= min_bcd_d;
            sec_bcd_q <= sec_bcd_d;
        end
    end

    assign min_bcd = min_bcd_q;
    assign sec_bcd = sec_bcd_q;
`endif

endmodule
